// File: rtl/plot_receiver.sv
// plot_receiver: accepts pixel plot requests, range-checks them, queues them in
// a small FIFO and issues them one at a time to a framebuffer write port that
// can stall. Out-of-range requests are counted; requests arriving while the
// FIFO is full are dropped and flagged.
module plot_receiver #(
  parameter int DEPTH = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_plot,
  output logic        in_ready,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_busy,
  output logic [4:0]  fifo_level,
  output logic [7:0]  drop_count,
  output logic        overflow
);

  localparam int             PTR_W  = $clog2(DEPTH);
  localparam logic [4:0]     DEPTH5 = 5'(DEPTH);
  localparam logic [8:0]     SCR_W9 = 9'(SCR_W);
  localparam logic [7:0]     SCR_H8 = 8'(SCR_H);
  localparam logic [14:0]    SCR_WA = 15'(SCR_W);

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // FIFO entry layout: {x[7:0], y[6:0], colour[2:0]}
  logic [17:0]      r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [4:0]       r_level;
  logic [14:0]      r_addr;
  logic [2:0]       r_data;
  logic             r_we;
  logic [7:0]       r_drop;
  logic             r_ovf;

  logic        w_in_range;
  logic        w_push;
  logic        w_pop;
  logic        w_complete;
  logic [17:0] w_head;
  logic [7:0]  w_head_x;
  logic [6:0]  w_head_y;
  logic [2:0]  w_head_c;
  logic [14:0] w_head_addr;

  assign in_ready   = (r_level != DEPTH5);
  assign w_in_range = ({1'b0, in_x} < SCR_W9) && ({1'b0, in_y} < SCR_H8);
  assign w_push     = in_plot && in_ready && w_in_range;
  assign w_complete = r_we && !mem_busy;
  // Refill the output register whenever it is empty or its write finishes now,
  // so a drained FIFO streams one write per cycle.
  assign w_pop      = (r_level != 5'd0) && (!r_we || !mem_busy);

  assign w_head      = r_fifo[r_rptr];
  assign w_head_x    = w_head[17:10];
  assign w_head_y    = w_head[9:3];
  assign w_head_c    = w_head[2:0];
  assign w_head_addr = ({8'd0, w_head_y} * SCR_WA) + {7'd0, w_head_x};

  // FIFO storage: data only, validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {in_x, in_y, in_colour};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 5'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Output write register: holds address/colour stable until the write completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_addr <= 15'd0;
      r_data <= 3'd0;
    end else if (w_pop) begin
      r_we   <= 1'b1;
      r_addr <= w_head_addr;
      r_data <= w_head_c;
    end else if (w_complete) begin
      r_we   <= 1'b0;
    end
  end

  // Error bookkeeping: a full-FIFO drop takes precedence over a range drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop <= 8'd0;
      r_ovf  <= 1'b0;
    end else if (in_plot && !in_ready) begin
      r_ovf  <= 1'b1;
    end else if (in_plot && !w_in_range) begin
      r_drop <= sat_inc8(r_drop);
    end
  end

  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign mem_we     = r_we;
  assign fifo_level = r_level;
  assign drop_count = r_drop;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_plot_receiver.sv
// tb_plot_receiver: randomized and directed stimulus against a queue-level
// model; expected writes go into a scoreboard that a separate monitor drains.
module tb_plot_receiver;

  localparam int DEPTH = 8;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic        in_ready;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_busy;
  logic [4:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        overflow;

  always #5 clk = ~clk;

  plot_receiver #(.DEPTH(DEPTH), .SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
    .clk(clk), .reset_n(reset_n), .in_x(in_x), .in_y(in_y),
    .in_colour(in_colour), .in_plot(in_plot), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_busy(mem_busy), .fifo_level(fifo_level), .drop_count(drop_count),
    .overflow(overflow)
  );

  typedef struct {int addr; int col;} wr_t;
  wr_t sb[$];

  int errors = 0;
  int checks = 0;
  int n_writes = 0;

  // Model state: entries waiting in the queue, whether one is presented to
  // memory, and the error counters.
  int m_cnt = 0;
  bit m_rv = 0;
  int m_drop = 0;
  bit m_ovf = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every completed write must match the next scoreboard entry.
  wr_t         mon_e;
  logic        prev_stall = 1'b0;
  logic [14:0] prev_addr;
  logic [2:0]  prev_data;
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      if (prev_stall) begin
        chk("hold_addr", int'(mem_addr), int'(prev_addr));
        chk("hold_data", int'(mem_data), int'(prev_data));
      end
      if (!mem_busy) begin
        n_writes++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d expected no write", mem_addr);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", int'(mem_addr), mon_e.addr);
          chk("wr_data", int'(mem_data), mon_e.col);
        end
      end
    end
    prev_stall = reset_n && mem_we && mem_busy;
    prev_addr  = mem_addr;
    prev_data  = mem_data;
  end

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit plot, input int x, input int y, input int col, input bit busy);
    bit ready, inr, push, pop;
    in_plot   = plot;
    in_x      = x[7:0];
    in_y      = y[6:0];
    in_colour = col[2:0];
    mem_busy  = busy;
    @(negedge clk);
    ready = (m_cnt != DEPTH);
    chk("in_ready",   int'(in_ready),   int'(ready));
    chk("fifo_level", int'(fifo_level), m_cnt);
    chk("mem_we",     int'(mem_we),     int'(m_rv));
    chk("drop_count", int'(drop_count), m_drop);
    chk("overflow",   int'(overflow),   int'(m_ovf));
    inr  = (x < SCR_W) && (y < SCR_H);
    push = plot && ready && inr;
    if (plot && !ready) m_ovf = 1'b1;
    else if (plot && !inr && m_drop < 255) m_drop++;
    if (push) sb.push_back('{y * SCR_W + x, col});
    pop = (m_cnt > 0) && (!m_rv || !busy);
    if (pop) m_rv = 1'b1;
    else if (m_rv && !busy) m_rv = 1'b0;
    m_cnt = m_cnt + int'(push) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_mem_we",   int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    chk("rst_level",    int'(fifo_level), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_drop",     int'(drop_count), 0);
    chk("rst_overflow", int'(overflow), 0);
  endtask

  // Reset pulsed in the middle of a cycle, away from the clock edges.
  task automatic do_reset();
    #1 reset_n = 1'b0;
    in_plot = 1'b0;
    #1;
    check_reset_state();
    m_cnt = 0; m_rv = 0; m_drop = 0; m_ovf = 0;
    sb.delete();
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int n0;
  bit rb;

  initial begin
    reset_n = 1'b0; in_plot = 1'b0; in_x = '0; in_y = '0; in_colour = '0; mem_busy = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_reset_state();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single plot and its one-edge latency.
    cycle(1, 5, 2, 3'b100, 0);
    cycle(0, 0, 0, 0, 0);
    #3;
    chk("lat_we",   int'(mem_we), 1);
    chk("lat_addr", int'(mem_addr), 325);
    chk("lat_data", int'(mem_data), 3'b100);
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Fill under stall until a request overflows, then drain in order.
    for (int i = 0; i < 10; i++) cycle(1, i * 7, i * 3, i % 8, 1);
    chk("full_level",   int'(fifo_level), 8);
    chk("full_ready",   int'(in_ready), 0);
    chk("full_ovf",     int'(overflow), 1);
    n0 = n_writes;
    repeat (14) cycle(0, 0, 0, 0, 0);
    chk("burst_writes", n_writes - n0, 9);

    // Range boundaries.
    do_reset();
    cycle(1, 160, 0, 1, 0);
    cycle(1, 0, 120, 2, 0);
    cycle(1, 159, 119, 5, 0);
    n0 = n_writes;
    repeat (4) cycle(0, 0, 0, 0, 0);
    chk("bound_drop",   int'(drop_count), 2);
    chk("bound_writes", n_writes - n0, 1);

    // Drop counter saturation.
    n0 = n_writes;
    for (int i = 0; i < 300; i++) begin
      rb = $urandom_range(0, 1);
      if (rb) cycle(1, $urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7), 0);
      else    cycle(1, $urandom_range(0, 255), $urandom_range(120, 127), $urandom_range(0, 7), 0);
    end
    chk("sat_drop",   int'(drop_count), 255);
    chk("sat_writes", n_writes - n0, 0);

    // Reset with queued and pending writes: nothing may be issued afterwards.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 10 + i, 20 + i, i, 1);
    chk("pre_rst_level", int'(fifo_level), 5);
    do_reset();
    n0 = n_writes;
    repeat (10) cycle(0, 0, 0, 0, 0);
    chk("post_rst_writes", n_writes - n0, 0);

    // Flow-controlled continuous plots with the memory stalling every other cycle.
    for (int i = 0; i < 200; i++)
      cycle(m_cnt != DEPTH, $urandom_range(0, SCR_W - 1), $urandom_range(0, SCR_H - 1),
            $urandom_range(0, 7), i[0]);
    chk("toggle_ovf", int'(overflow), 0);
    repeat (20) cycle(0, 0, 0, 0, 0);

    // Fully random traffic.
    do_reset();
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 175), $urandom_range(0, 127),
            $urandom_range(0, 7), $urandom_range(0, 9) < 4);
    repeat (20) cycle(0, 0, 0, 0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
